// File: rtl/mds_mul_pipe.sv
// Pipelined Twofish MDS multiply over GF(2^8), poly 0x169, on LANES 32-bit words per beat.
// Latency: PIPE_STAGES cycles from input transfer to out_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: full valid/ready; stages compact into bubbles, in_ready falls only when every stage is full.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_data (32*LANES) and in_tag are sampled on transfer
//   out_valid/out_ready      output handshake; out_data/out_tag hold stable while stalled
//   occupancy                number of stages currently holding a valid beat
module mds_mul_pipe #(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [32*LANES-1:0]                  in_data,
  input  logic [TAG_W-1:0]                     in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [32*LANES-1:0]                  out_data,
  output logic [TAG_W-1:0]                     out_tag,
  output logic [$clog2(PIPE_STAGES+1)-1:0]     occupancy
);

  localparam int DW    = 32 * LANES;
  localparam int OCC_W = $clog2(PIPE_STAGES + 1);

  // Multiply by x, reducing by x^8+x^6+x^5+x^3+1 (low byte 0x69).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h69 : 8'h00);
  endfunction

  // 0x5B = x^6+x^4+x^3+x+1
  function automatic logic [7:0] mul_5b(input logic [7:0] a);
    logic [7:0] x1, x2, x3, x4, x6;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    x4 = xtime(x3);
    x6 = xtime(xtime(x4));
    return a ^ x1 ^ x3 ^ x4 ^ x6;
  endfunction

  // 0xEF = x^7+x^6+x^5+x^3+x^2+x+1
  function automatic logic [7:0] mul_ef(input logic [7:0] a);
    logic [7:0] x1, x2, x3, x4, x5, x6, x7;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    x4 = xtime(x3);
    x5 = xtime(x4);
    x6 = xtime(x5);
    x7 = xtime(x6);
    return a ^ x1 ^ x2 ^ x3 ^ x5 ^ x6 ^ x7;
  endfunction

  // z = MDS * y, byte 0 is the LSB on both sides.
  function automatic logic [31:0] mds_word(input logic [31:0] y);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = y[7:0];
    y1 = y[15:8];
    y2 = y[23:16];
    y3 = y[31:24];
    z0 = y0         ^ mul_ef(y1) ^ mul_5b(y2) ^ mul_5b(y3);
    z1 = mul_5b(y0) ^ mul_ef(y1) ^ mul_ef(y2) ^ y3;
    z2 = mul_ef(y0) ^ mul_5b(y1) ^ y2         ^ mul_ef(y3);
    z3 = mul_ef(y0) ^ y1         ^ mul_ef(y2) ^ mul_5b(y3);
    return {z3, z2, z1, z0};
  endfunction

  logic             valid_q    [1:PIPE_STAGES];
  logic             valid_d    [1:PIPE_STAGES];
  logic [DW-1:0]    data_q     [1:PIPE_STAGES];
  logic [DW-1:0]    data_d     [1:PIPE_STAGES];
  logic [TAG_W-1:0] tag_q      [1:PIPE_STAGES];
  logic [TAG_W-1:0] tag_d      [1:PIPE_STAGES];
  logic             adv        [1:PIPE_STAGES];
  // stage_free[i]: stage i can take a beat this cycle; entry PIPE_STAGES+1 is the downstream sink.
  logic             stage_free [1:PIPE_STAGES+1];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DW-1:0]    mds_res;
  logic             in_xfer;
  logic             out_xfer;

  // All arithmetic sits in front of stage 1; later stages only delay.
  always_comb begin
    mds_res = '0;
    for (int k = 0; k < LANES; k++) begin
      mds_res[32*k +: 32] = mds_word(in_data[32*k +: 32]);
    end
  end

  // Ready ripples backwards from the sink so a stalled tail still lets upstream bubbles close.
  always_comb begin
    stage_free = '{default: 1'b0};
    adv        = '{default: 1'b0};
    stage_free[PIPE_STAGES+1] = out_ready;
    for (int i = PIPE_STAGES; i >= 1; i--) begin
      adv[i]        = valid_q[i] && stage_free[i+1];
      stage_free[i] = !valid_q[i] || adv[i];
    end
  end

  assign in_ready = stage_free[1];
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = adv[PIPE_STAGES];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    // A stage that hands its beat on is empty unless refilled below.
    for (int i = 1; i <= PIPE_STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (in_xfer) begin
      valid_d[1] = 1'b1;
      data_d[1]  = mds_res;
      tag_d[1]   = in_tag;
    end
    for (int i = 2; i <= PIPE_STAGES; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Data registers are cleared too so out_data reads 0 until the first beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
      data_q  <= '{default: '0};
      tag_q   <= '{default: '0};
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[PIPE_STAGES];
  assign out_data  = data_q[PIPE_STAGES];
  assign out_tag   = tag_q[PIPE_STAGES];
  assign occupancy = occ_q;

endmodule
